// File: rtl/mem_stage_access_if.sv
// Requester/controller link for the byte-serial memory data port.
// Level request held with stable fields until the controller's one-cycle done pulse.
interface mem_stage_access_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mc_req_out;
    logic              mc_rw_out;
    logic [ADDR_W-1:0] mc_addr_out;
    logic [DATA_W-1:0] mc_data_out;
    logic [2:0]        mc_len_out;
    logic              mc_done_in;
    logic [DATA_W-1:0] mc_data_in;

    modport master (
        output mc_req_out, mc_rw_out, mc_addr_out, mc_data_out, mc_len_out,
        input  mc_done_in, mc_data_in
    );

    modport slave (
        input  mc_req_out, mc_rw_out, mc_addr_out, mc_data_out, mc_len_out,
        output mc_done_in, mc_data_in
    );
endinterface

// File: rtl/mem_stage_access.sv
// MEM stage: turns EX loads/stores into one controller request and forwards a WB record.
// Latency 1 for pass-through ops, done+1 for memory ops; stalls EX while an access is outstanding.
module mem_stage_access #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                ex_valid_in,
    input  logic                ex_load_in,
    input  logic                ex_store_in,
    input  logic [2:0]          ex_funct3_in,
    input  logic [ADDR_W-1:0]   ex_addr_in,
    input  logic [DATA_W-1:0]   ex_storeData_in,
    input  logic [4:0]          ex_rd_in,
    input  logic                ex_wreg_in,
    input  logic [DATA_W-1:0]   ex_result_in,
    output logic                stall_out,
    mem_stage_access_if.master  mc,
    output logic                wb_valid_out,
    output logic                wb_we_out,
    output logic [4:0]          wb_rd_out,
    output logic [DATA_W-1:0]   wb_data_out
);
    typedef enum logic {IDLE, ACCESS} state_t;

    state_t              state_q, state_d;
    logic [2:0]          f3_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   sdata_q;
    logic [4:0]          rd_q;
    logic                wreg_q;
    logic                rw_q;
    logic                latch_en;

    logic                wb_valid_d, wb_we_d;
    logic [4:0]          wb_rd_d;
    logic [DATA_W-1:0]   wb_data_d;
    logic [DATA_W-1:0]   load_ext;
    logic [2:0]          len;
    logic                in_access;

    assign in_access = (state_q == ACCESS);

    always_comb begin
        len = 3'd4;
        case (f3_q[1:0])
            2'b00:   len = 3'd1;
            2'b01:   len = 3'd2;
            default: len = 3'd4;
        endcase
    end

    always_comb begin
        load_ext = mc.mc_data_in;
        case (f3_q)
            3'b000:  load_ext = {{(DATA_W-8){mc.mc_data_in[7]}},   mc.mc_data_in[7:0]};
            3'b001:  load_ext = {{(DATA_W-16){mc.mc_data_in[15]}}, mc.mc_data_in[15:0]};
            3'b100:  load_ext = {{(DATA_W-8){1'b0}},  mc.mc_data_in[7:0]};
            3'b101:  load_ext = {{(DATA_W-16){1'b0}}, mc.mc_data_in[15:0]};
            default: load_ext = mc.mc_data_in;
        endcase
    end

    // Request drops in the done cycle so the controller never sees a second start.
    assign mc.mc_req_out  = in_access && !mc.mc_done_in;
    assign mc.mc_rw_out   = in_access ? rw_q    : 1'b0;
    assign mc.mc_addr_out = in_access ? addr_q  : '0;
    assign mc.mc_data_out = in_access ? sdata_q : '0;
    assign mc.mc_len_out  = in_access ? len     : 3'd0;
    assign stall_out      = in_access && !mc.mc_done_in;

    always_comb begin
        state_d    = state_q;
        latch_en   = 1'b0;
        wb_valid_d = 1'b0;
        wb_we_d    = 1'b0;
        wb_rd_d    = 5'd0;
        wb_data_d  = '0;
        case (state_q)
            IDLE: begin
                if (ex_valid_in) begin
                    if (ex_load_in || ex_store_in) begin
                        latch_en = 1'b1;
                        state_d  = ACCESS;
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_we_d    = ex_wreg_in;
                        wb_rd_d    = ex_rd_in;
                        wb_data_d  = ex_result_in;
                    end
                end
            end
            ACCESS: begin
                if (mc.mc_done_in) begin
                    state_d    = IDLE;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_we_d    = rw_q ? 1'b0 : wreg_q;
                    wb_data_d  = rw_q ? '0   : load_ext;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= IDLE;
            f3_q         <= 3'd0;
            addr_q       <= '0;
            sdata_q      <= '0;
            rd_q         <= 5'd0;
            wreg_q       <= 1'b0;
            rw_q         <= 1'b0;
            wb_valid_out <= 1'b0;
            wb_we_out    <= 1'b0;
            wb_rd_out    <= 5'd0;
            wb_data_out  <= '0;
        end else begin
            state_q      <= state_d;
            wb_valid_out <= wb_valid_d;
            wb_we_out    <= wb_we_d;
            wb_rd_out    <= wb_rd_d;
            wb_data_out  <= wb_data_d;
            if (latch_en) begin
                f3_q    <= ex_funct3_in;
                addr_q  <= ex_addr_in;
                sdata_q <= ex_storeData_in;
                rd_q    <= ex_rd_in;
                wreg_q  <= ex_wreg_in;
                rw_q    <= ex_store_in;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage_access.sv
// Directed bench for mem_stage_access: table of load/store vectors plus hand-written corner sequences.
module tb_mem_stage_access;
    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        ex_valid_in, ex_load_in, ex_store_in, ex_wreg_in;
    logic [2:0]  ex_funct3_in;
    logic [31:0] ex_addr_in, ex_storeData_in, ex_result_in;
    logic [4:0]  ex_rd_in;
    logic        stall_out, wb_valid_out, wb_we_out;
    logic [4:0]  wb_rd_out;
    logic [31:0] wb_data_out;

    int checks = 0;
    int errors = 0;

    mem_stage_access_if #(.ADDR_W(32), .DATA_W(32)) mc_bus ();

    mem_stage_access #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .ex_valid_in(ex_valid_in), .ex_load_in(ex_load_in), .ex_store_in(ex_store_in),
        .ex_funct3_in(ex_funct3_in), .ex_addr_in(ex_addr_in), .ex_storeData_in(ex_storeData_in),
        .ex_rd_in(ex_rd_in), .ex_wreg_in(ex_wreg_in), .ex_result_in(ex_result_in),
        .stall_out(stall_out), .mc(mc_bus),
        .wb_valid_out(wb_valid_out), .wb_we_out(wb_we_out),
        .wb_rd_out(wb_rd_out), .wb_data_out(wb_data_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic        wreg;
        logic [31:0] ret;
        logic [2:0]  exp_len;
        logic        exp_we;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] sd, input logic [4:0] rd, input logic wreg,
                                input logic [31:0] ret, input logic [2:0] exp_len,
                                input logic exp_we, input logic [31:0] exp_data);
        vec_t v;
        v.st = st; v.f3 = f3; v.addr = addr; v.sd = sd; v.rd = rd; v.wreg = wreg;
        v.ret = ret; v.exp_len = exp_len; v.exp_we = exp_we; v.exp_data = exp_data;
        return v;
    endfunction

    task automatic idle_inputs();
        ex_valid_in = 1'b0; ex_load_in = 1'b0; ex_store_in = 1'b0; ex_wreg_in = 1'b0;
        ex_funct3_in = 3'd0; ex_addr_in = 32'd0; ex_storeData_in = 32'd0;
        ex_rd_in = 5'd0; ex_result_in = 32'd0;
    endtask

    // Issue one memory op, play the controller (done len+1 cycles after req rises), check WB.
    task automatic run_mem(input vec_t v, input string tag);
        int req_cycles;
        @(negedge clk_in);
        ex_valid_in = 1'b1; ex_load_in = !v.st; ex_store_in = v.st;
        ex_funct3_in = v.f3; ex_addr_in = v.addr; ex_storeData_in = v.sd;
        ex_rd_in = v.rd; ex_wreg_in = v.wreg; ex_result_in = 32'hBAD0BAD0;
        @(negedge clk_in);
        ex_valid_in = 1'b0; ex_load_in = 1'b0; ex_store_in = 1'b0;
        chk({tag, " stall"}, {31'd0, stall_out}, 32'd1);
        chk({tag, " rw"},    {31'd0, mc_bus.mc_rw_out}, {31'd0, v.st});
        chk({tag, " addr"},  mc_bus.mc_addr_out, v.addr);
        chk({tag, " mdata"}, mc_bus.mc_data_out, v.sd);
        chk({tag, " len"},   {29'd0, mc_bus.mc_len_out}, {29'd0, v.exp_len});
        chk({tag, " wbv_wait"}, {31'd0, wb_valid_out}, 32'd0);
        req_cycles = 0;
        for (int k = 0; k <= int'(v.exp_len); k++) begin
            if (k > 0) @(negedge clk_in);
            if (mc_bus.mc_req_out) req_cycles++;
        end
        @(negedge clk_in);
        mc_bus.mc_done_in = 1'b1; mc_bus.mc_data_in = v.ret;
        #1;
        chk({tag, " req_done"},   {31'd0, mc_bus.mc_req_out}, 32'd0);
        chk({tag, " stall_done"}, {31'd0, stall_out}, 32'd0);
        chk({tag, " req_cycles"}, req_cycles, int'(v.exp_len) + 1);
        @(negedge clk_in);
        mc_bus.mc_done_in = 1'b0; mc_bus.mc_data_in = 32'd0;
        chk({tag, " wb_valid"}, {31'd0, wb_valid_out}, 32'd1);
        chk({tag, " wb_we"},    {31'd0, wb_we_out}, {31'd0, v.exp_we});
        chk({tag, " wb_rd"},    {27'd0, wb_rd_out}, {27'd0, v.rd});
        chk({tag, " wb_data"},  wb_data_out, v.exp_data);
        @(negedge clk_in);
        chk({tag, " wb_once"},  {31'd0, wb_valid_out}, 32'd0);
    endtask

    initial begin
        //            st    f3      addr          sd            rd     wreg  ret           len   we    exp_data
        vecs[0] = mk(1'b0, 3'b000, 32'h0000_0100, 32'h0,        5'd1,  1'b1, 32'h0000_0080, 3'd1, 1'b1, 32'hFFFF_FF80);
        vecs[1] = mk(1'b0, 3'b101, 32'h0000_0200, 32'h0,        5'd2,  1'b1, 32'h0000_F00D, 3'd2, 1'b1, 32'h0000_F00D);
        vecs[2] = mk(1'b0, 3'b001, 32'h0000_0202, 32'h0,        5'd3,  1'b1, 32'h0000_F00D, 3'd2, 1'b1, 32'hFFFF_F00D);
        vecs[3] = mk(1'b0, 3'b010, 32'h0000_0300, 32'h0,        5'd4,  1'b1, 32'h1234_5678, 3'd4, 1'b1, 32'h1234_5678);
        vecs[4] = mk(1'b0, 3'b100, 32'h0000_0305, 32'h0,        5'd6,  1'b1, 32'h0000_00F5, 3'd1, 1'b1, 32'h0000_00F5);
        vecs[5] = mk(1'b1, 3'b010, 32'h0000_1003, 32'hDEADBEEF, 5'd9,  1'b0, 32'hAAAA_AAAA, 3'd4, 1'b0, 32'h0);
        vecs[6] = mk(1'b1, 3'b000, 32'h0000_2001, 32'h0000_0011, 5'd10, 1'b0, 32'h5555_5555, 3'd1, 1'b0, 32'h0);
        vecs[7] = mk(1'b0, 3'b000, 32'h0000_0101, 32'h0,        5'd11, 1'b1, 32'h0000_007F, 3'd1, 1'b1, 32'h0000_007F);
        vecs[8] = mk(1'b0, 3'b010, 32'h0000_0400, 32'h0,        5'd12, 1'b0, 32'h8765_4321, 3'd4, 1'b0, 32'h8765_4321);
        vecs[9] = mk(1'b0, 3'b011, 32'h0000_0500, 32'h0,        5'd13, 1'b1, 32'hCAFE_F00D, 3'd4, 1'b1, 32'hCAFE_F00D);

        idle_inputs();
        mc_bus.mc_done_in = 1'b0; mc_bus.mc_data_in = 32'd0;
        rst_in = 1'b1;
        @(negedge clk_in);
        chk("rst wb_valid", {31'd0, wb_valid_out}, 32'd0);
        chk("rst req",      {31'd0, mc_bus.mc_req_out}, 32'd0);
        chk("rst len",      {29'd0, mc_bus.mc_len_out}, 32'd0);
        chk("rst stall",    {31'd0, stall_out}, 32'd0);
        chk("rst wb_data",  wb_data_out, 32'd0);
        rst_in = 1'b0;

        // Pass-through ALU record.
        @(negedge clk_in);
        ex_valid_in = 1'b1; ex_rd_in = 5'd5; ex_wreg_in = 1'b1; ex_result_in = 32'h1234;
        #1 chk("alu stall0", {31'd0, stall_out}, 32'd0);
        @(negedge clk_in);
        ex_valid_in = 1'b0;
        chk("alu wb_valid", {31'd0, wb_valid_out}, 32'd1);
        chk("alu wb_we",    {31'd0, wb_we_out}, 32'd1);
        chk("alu wb_rd",    {27'd0, wb_rd_out}, 32'd5);
        chk("alu wb_data",  wb_data_out, 32'h1234);
        chk("alu stall1",   {31'd0, stall_out}, 32'd0);
        chk("alu req",      {31'd0, mc_bus.mc_req_out}, 32'd0);
        @(negedge clk_in);
        chk("alu wb_once",  {31'd0, wb_valid_out}, 32'd0);

        for (int i = 0; i < 10; i++) run_mem(vecs[i], $sformatf("vec%0d", i));

        // Done pulse while idle is ignored.
        @(negedge clk_in);
        mc_bus.mc_done_in = 1'b1; mc_bus.mc_data_in = 32'hFFFF_FFFF;
        #1 chk("idle_done req", {31'd0, mc_bus.mc_req_out}, 32'd0);
        @(negedge clk_in);
        mc_bus.mc_done_in = 1'b0; mc_bus.mc_data_in = 32'd0;
        chk("idle_done wbv", {31'd0, wb_valid_out}, 32'd0);

        // LW followed immediately by an ALU op held under stall.
        @(negedge clk_in);
        ex_valid_in = 1'b1; ex_load_in = 1'b1; ex_funct3_in = 3'b010; ex_addr_in = 32'h400;
        ex_rd_in = 5'd3; ex_wreg_in = 1'b1;
        @(negedge clk_in);
        ex_load_in = 1'b0; ex_rd_in = 5'd7; ex_result_in = 32'h55;
        chk("b2b stall c0", {31'd0, stall_out}, 32'd1);
        repeat (4) @(negedge clk_in);
        chk("b2b stall c4", {31'd0, stall_out}, 32'd1);
        chk("b2b wbv c4",   {31'd0, wb_valid_out}, 32'd0);
        @(negedge clk_in);
        mc_bus.mc_done_in = 1'b1; mc_bus.mc_data_in = 32'h8000_0001;
        #1 chk("b2b stall done", {31'd0, stall_out}, 32'd0);
        @(negedge clk_in);
        mc_bus.mc_done_in = 1'b0; mc_bus.mc_data_in = 32'd0;
        chk("b2b lw wbv",  {31'd0, wb_valid_out}, 32'd1);
        chk("b2b lw rd",   {27'd0, wb_rd_out}, 32'd3);
        chk("b2b lw data", wb_data_out, 32'h8000_0001);
        chk("b2b no req",  {31'd0, mc_bus.mc_req_out}, 32'd0);
        @(negedge clk_in);
        ex_valid_in = 1'b0;
        chk("b2b alu wbv",  {31'd0, wb_valid_out}, 32'd1);
        chk("b2b alu rd",   {27'd0, wb_rd_out}, 32'd7);
        chk("b2b alu data", wb_data_out, 32'h55);
        chk("b2b no req2",  {31'd0, mc_bus.mc_req_out}, 32'd0);
        @(negedge clk_in);
        chk("b2b wb_once",  {31'd0, wb_valid_out}, 32'd0);
        idle_inputs();

        // Async reset in the middle of a LW.
        @(negedge clk_in);
        ex_valid_in = 1'b1; ex_load_in = 1'b1; ex_funct3_in = 3'b010; ex_addr_in = 32'h600;
        ex_rd_in = 5'd8; ex_wreg_in = 1'b1;
        @(negedge clk_in);
        idle_inputs();
        chk("mid req before", {31'd0, mc_bus.mc_req_out}, 32'd1);
        @(negedge clk_in);
        rst_in = 1'b1;
        #1;
        chk("mid req",   {31'd0, mc_bus.mc_req_out}, 32'd0);
        chk("mid stall", {31'd0, stall_out}, 32'd0);
        chk("mid len",   {29'd0, mc_bus.mc_len_out}, 32'd0);
        chk("mid addr",  mc_bus.mc_addr_out, 32'd0);
        chk("mid wbv",   {31'd0, wb_valid_out}, 32'd0);
        @(negedge clk_in);
        rst_in = 1'b0;
        run_mem(vecs[0], "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_stage_access.md
Name: mem_stage_access

Overview:
- Pipeline MEM stage that is the requester side of the byte-serial memory controller's data port.
- Accepts load/store and pass-through ops from EX and converts each load/store into one controller request (rw, addr, data, len).
- Holds the request until the controller's done pulse, then sign-/zero-extends load data and forwards a writeback record to WB.
- Stalls upstream while an access is outstanding.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data and result width.

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  reset, asynchronous, active-high.
- ex_valid_in  input  1  EX record valid this cycle.
- ex_load_in  input  1  record is a load.
- ex_store_in  input  1  record is a store (never both set with ex_load_in).
- ex_funct3_in  input  3  RISC-V funct3 of the load/store.
- ex_addr_in  input  32  effective address.
- ex_storeData_in  input  32  store data (rs2).
- ex_rd_in  input  5  destination register.
- ex_wreg_in  input  1  record writes rd.
- ex_result_in  input  32  ALU result for non-memory records.
- stall_out  output  1  upstream must hold ex_* stable.
- mc_req_out  output  1  memory request, level.
- mc_rw_out  output  1  0 = read, 1 = write.
- mc_addr_out  output  32  base byte address.
- mc_data_out  output  32  store data, byte 0 in [7:0].
- mc_len_out  output  3  byte count: 1, 2 or 4.
- mc_done_in  input  1  one-cycle pulse: access complete (load data valid, or store finished).
- mc_data_in  input  32  load bytes zero-padded, byte 0 in [7:0].
- wb_valid_out  output  1  WB record valid.
- wb_we_out  output  1  write rd.
- wb_rd_out  output  5  destination register.
- wb_data_out  output  32  result.

Behaviour:
- Reset (async, rst_in = 1): state = IDLE; all latched fields = 0; every output = 0, including mc_len_out = 0. Takes effect immediately, including mid-access; mc_req_out drops in the same cycle. Controller aborts when its request drops.
- FSM states: IDLE, ACCESS.
- IDLE, ex_valid_in = 1, neither load nor store:
  - Next edge: wb_valid = 1, wb_we = ex_wreg_in, wb_rd = ex_rd_in, wb_data = ex_result_in.
  - Latency 1, no stall.
- IDLE, ex_valid_in = 1 with load or store:
  - Latch funct3, addr, storeData, rd, wreg, rw (store = 1).
  - Go to ACCESS.
  - wb_valid = 0 next cycle.
- IDLE, ex_valid_in = 0: wb_valid = 0.
- ACCESS:
  - mc_req_out = 1 AND NOT mc_done_in (combinational). The request drops in the done cycle, so the controller does not restart.
  - mc_addr, mc_data, mc_rw, mc_len are driven from latched fields and stay stable for the whole access.
  - wb_valid = 0 while waiting.
- Length mapping from funct3[1:0]: 00 -> 1; 01 -> 2; 10 -> 4; 11 (illegal) -> 4.
- Load extension is applied to mc_data_in in the done cycle:
  - 000 LB: sign-extend bit 7.
  - 001 LH: sign-extend bit 15.
  - 010 LW: raw.
  - 100 LBU: zero-extend [7:0].
  - 101 LHU: zero-extend [15:0].
  - Others: raw.
- ACCESS with mc_done_in = 1, at the next edge:
  - State = IDLE.
  - wb_valid = 1.
  - Load: wb_we = latched wreg, wb_data = extended value.
  - Store: wb_we = 0, wb_data = 0.
  - wb_rd = latched rd.
- stall_out = (state == ACCESS) AND NOT mc_done_in.
  - The record following a memory op is held until the done cycle.
  - That record is consumed in IDLE on the first edge after returning to IDLE.
- mc_done_in while in IDLE: ignored.
- Addresses are unaligned-tolerant: passed through unchanged, no alignment check.
- Expected controller timing: done arrives len+1 cycles after mc_req_out rises.
- wb_* are registered and hold for exactly one cycle per record.

Test Plan:
- Pass-through: ALU record rd = 5, result = 0x1234 -> next cycle wb_valid = 1, wb_we = 1, rd = 5, data = 0x1234; stall_out never asserted.
- LB: addr 0x100, model returns 0x00000080 -> mc_len = 1, mc_rw = 0, req high 2 cycles; wb_data = 0xFFFFFF80 one cycle after done.
- LHU/LH: model returns 0x0000F00D -> LHU gives 0x0000F00D; LH gives 0xFFFFF00D; mc_len = 2.
- SW: addr 0x1003, data 0xDEADBEEF -> mc_rw = 1, addr = 0x1003, len = 4, req drops in the done cycle; wb_valid = 1, wb_we = 0.
- Back-to-back: LW then ALU op -> stall high until the done cycle; the ALU result reaches WB exactly 1 cycle after the LW's WB record; no second controller request.
- Async reset asserted mid-LW -> mc_req_out and all outputs 0 immediately; after release, the next load is issued cleanly.
